// File: rtl/bundle_feeder.sv
// Transmit-side sequencer for the majority-bundling counter bank: clears the
// counters, feeds one word per update slot and pulses done when sign bits settle.
module bundle_feeder #(
  parameter int          W         = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  n_items,
  input  logic [4:0]   cfg_remainder,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         cnt_clr,
  output logic         cnt_even,
  output logic         cnt_tie,
  output logic [W-1:0] cnt_result,
  output logic         cnt_update,
  output logic         cnt_last_update,
  output logic [4:0]   cnt_remainder,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_ISSUE, S_GAP, S_DRAIN1, S_DRAIN2, S_DONE
  } state_t;

  state_t         r_state, w_next;
  logic [15:0]    r_n, r_cnt, r_lfsr;
  logic           r_tie, r_even;
  logic [4:0]     r_rem;
  logic [W-1:0]   r_result;
  logic           w_ready, w_hs, w_more, w_start_ok;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  assign w_more     = (r_cnt != r_n);
  assign w_hs       = s_valid & w_ready;
  assign w_start_ok = (r_state == S_IDLE) & start;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_CLEAR;
      S_CLEAR:  w_next = (r_n == 16'd0) ? S_DRAIN1 : S_FETCH;
      S_FETCH:  if (w_hs) w_next = S_ISSUE;
      S_ISSUE:  w_next = S_GAP;
      // The gap cycle keeps updates two cycles apart; it may already fetch.
      S_GAP:    w_next = !w_more ? S_DRAIN1 : (w_hs ? S_ISSUE : S_FETCH);
      S_DRAIN1: w_next = S_DRAIN2;
      S_DRAIN2: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready         = (r_state == S_FETCH) | ((r_state == S_GAP) & w_more);
    s_ready         = w_ready;
    cnt_clr         = (r_state == S_CLEAR);
    cnt_update      = (r_state == S_ISSUE);
    cnt_last_update = (r_state == S_ISSUE) & (r_cnt == r_n - 16'd1);
    busy            = (r_state != S_IDLE);
    done            = (r_state == S_DONE);
  end

  // Job parameters, item counter and captured word; all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n      <= '0;
      r_cnt    <= '0;
      r_lfsr   <= LFSR_SEED;
      r_tie    <= 1'b0;
      r_even   <= 1'b0;
      r_rem    <= '0;
      r_result <= '0;
    end else begin
      if (w_start_ok) begin
        r_n    <= n_items;
        r_rem  <= cfg_remainder;
        r_even <= ~n_items[0];
        r_tie  <= r_lfsr[0];
        r_lfsr <= lfsr_step(r_lfsr);
        r_cnt  <= '0;
      end
      if (r_state == S_ISSUE) r_cnt <= r_cnt + 16'd1;
      if (w_hs)               r_result <= s_data;
    end
  end

  assign cnt_even      = r_even;
  assign cnt_tie       = r_tie;
  assign cnt_result    = r_result;
  assign cnt_remainder = r_rem;

endmodule

// File: tb/tb_bundle_feeder.sv
// Directed bench for bundle_feeder: job sequencing, update spacing, LFSR tie
// seed, handshake gating, ignored start and mid-job reset.
module tb_bundle_feeder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, s_valid;
  logic [15:0]  n_items;
  logic [4:0]   cfg_remainder;
  logic [W-1:0] s_data;
  logic         s_ready, cnt_clr, cnt_even, cnt_tie, cnt_update, cnt_last_update;
  logic         busy, done;
  logic [W-1:0] cnt_result;
  logic [4:0]   cnt_remainder;

  bundle_feeder #(.W(W), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .n_items(n_items),
    .cfg_remainder(cfg_remainder), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cnt_clr(cnt_clr), .cnt_even(cnt_even), .cnt_tie(cnt_tie),
    .cnt_result(cnt_result), .cnt_update(cnt_update),
    .cnt_last_update(cnt_last_update), .cnt_remainder(cnt_remainder),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          upd_n = 0, done_n = 0, clr_n = 0;
  int          upd_cyc [64];
  logic [31:0] upd_data [64];
  logic        upd_last [64];
  int          done_cyc = 0, clr_cyc = 0;
  logic        clr_even = 1'b0, clr_tie = 1'b0;

  always @(negedge clk) begin
    if (cnt_update) begin
      upd_cyc[upd_n % 64]  <= cyc;
      upd_data[upd_n % 64] <= cnt_result;
      upd_last[upd_n % 64] <= cnt_last_update;
      upd_n <= upd_n + 1;
    end
    if (done) begin
      done_cyc <= cyc;
      done_n   <= done_n + 1;
    end
    if (cnt_clr) begin
      clr_cyc  <= cyc;
      clr_even <= cnt_even;
      clr_tie  <= cnt_tie;
      clr_n    <= clr_n + 1;
    end
  end

  int          tests = 0, fails = 0;
  int          b_upd, b_done, b_clr;
  logic [31:0] words [0:7];
  bit          vpat [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {24'd0, busy, done, s_ready, cnt_clr, cnt_update,
                        cnt_last_update, cnt_even, cnt_tie}, 32'd0);
    chk({tag, "_res"}, cnt_result, 32'd0);
    chk({tag, "_rem"}, {27'd0, cnt_remainder}, 32'd0);
  endtask

  function automatic int upd_at(input int k);
    return upd_cyc[(b_upd + k) % 64];
  endfunction

  // Runs one job; vpat[0..vlen-1] is the per-cycle s_valid pattern.
  task automatic run_job(input string tag, input logic [15:0] n, input logic [4:0] rem,
                         input int vlen, input bit poke, input int rst_after);
    int idx, guard;
    bit poked, prev_upd, aborted;
    b_upd = upd_n; b_done = done_n; b_clr = clr_n;
    n_items = n; cfg_remainder = rem; start = 1'b1;
    tick();
    start = 1'b0; n_items = 16'd0; cfg_remainder = 5'd0;
    chk({tag, "_clear_state"}, {29'd0, cnt_clr, busy, s_ready}, 32'd6);
    idx = 0; guard = 0; poked = 0; prev_upd = 0; aborted = 0;
    while (done_n == b_done && guard < 300 && !aborted) begin
      if (rst_after != 0 && prev_upd && (upd_n - b_upd) == rst_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        aborted = 1;
        chk_zero({tag, "_after_rst"});
      end else begin
        s_valid = vpat[guard % vlen];
        s_data  = (s_valid && idx < 8) ? words[idx] : 32'hDEADBEEF;
        if (poke && !poked && cnt_update) begin
          start = 1'b1; n_items = 16'd1; cfg_remainder = 5'd31; poked = 1;
        end
        prev_upd = cnt_update;
        @(negedge clk);
        if (s_valid && s_ready) idx++;
        tick();
        start = 1'b0;
        guard++;
      end
    end
    s_valid = 1'b0;
    s_data  = '0;
    if (!aborted) chk({tag, "_done_seen"}, done_n - b_done, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_items = '0; cfg_remainder = '0;
    s_data = '0; s_valid = 1'b0;
    for (int i = 0; i < 8; i++) vpat[i] = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_zero("reset");

    // n=2 straight after reset: even job, tie = seed bit0 = 1
    words[0] = 32'hA5A5A5A5; words[1] = 32'h5A5A5A5A;
    run_job("j1", 16'd2, 5'd3, 1, 0, 0);
    chk("j1_even", {31'd0, clr_even}, 32'd1);
    chk("j1_tie", {31'd0, clr_tie}, 32'd1);
    chk("j1_nupd", upd_n - b_upd, 32'd2);
    chk("j1_w0", upd_data[b_upd % 64], 32'hA5A5A5A5);
    chk("j1_w1", upd_data[(b_upd + 1) % 64], 32'h5A5A5A5A);
    chk("j1_rem", {27'd0, cnt_remainder}, 32'd3);
    chk("j1_busy_after", {31'd0, busy}, 32'd0);
    tick();

    // Second n=2 job sees the stepped LFSR (ACE1 -> 5670, bit0 = 0)
    run_job("j2", 16'd2, 5'd0, 1, 0, 0);
    chk("j2_even", {31'd0, clr_even}, 32'd1);
    chk("j2_tie", {31'd0, clr_tie}, 32'd0);
    tick();

    // n=3, back-to-back valid; LFSR now AB38 -> tie 0
    words[0] = 32'hFFFF0000; words[1] = 32'h0F0F0F0F; words[2] = 32'h00000001;
    run_job("j3", 16'd3, 5'd5, 1, 0, 0);
    chk("j3_nupd", upd_n - b_upd, 32'd3);
    chk("j3_w0", upd_data[b_upd % 64], 32'hFFFF0000);
    chk("j3_w1", upd_data[(b_upd + 1) % 64], 32'h0F0F0F0F);
    chk("j3_w2", upd_data[(b_upd + 2) % 64], 32'h00000001);
    chk("j3_last", {29'd0, upd_last[b_upd % 64], upd_last[(b_upd + 1) % 64],
                    upd_last[(b_upd + 2) % 64]}, 32'b001);
    chk("j3_gap01", upd_at(1) - upd_at(0), 32'd2);
    chk("j3_gap12", upd_at(2) - upd_at(1), 32'd2);
    chk("j3_done_lat", done_cyc - upd_at(2), 32'd4);
    chk("j3_even", {31'd0, clr_even}, 32'd0);
    chk("j3_tie", {31'd0, clr_tie}, 32'd0);
    chk("j3_rem", {27'd0, cnt_remainder}, 32'd5);
    chk("j3_res_hold", cnt_result, 32'h00000001);
    tick();

    // Empty job: one clear, no updates, done 3 cycles after CLEAR
    run_job("j4", 16'd0, 5'd9, 1, 0, 0);
    chk("j4_nclr", clr_n - b_clr, 32'd1);
    chk("j4_nupd", upd_n - b_upd, 32'd0);
    chk("j4_done_lat", done_cyc - clr_cyc, 32'd3);
    chk("j4_even", {31'd0, clr_even}, 32'd1);
    tick();

    // s_valid 1-0-0-1 repeating: one handshake per 4 cycles
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1;
    run_job("j5", 16'd4, 5'd1, 4, 0, 0);
    chk("j5_nupd", upd_n - b_upd, 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("j5_w%0d", k), upd_data[(b_upd + k) % 64], words[k]);
      chk($sformatf("j5_last%0d", k), {31'd0, upd_last[(b_upd + k) % 64]},
          (k == 3) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("j5_gap%0d", k), upd_at(k + 1) - upd_at(k), 32'd4);
    for (int i = 0; i < 8; i++) vpat[i] = 1'b1;
    tick();

    // start pulsed during ISSUE must be ignored
    words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h4; words[3] = 32'h8;
    run_job("j6", 16'd4, 5'd6, 1, 1, 0);
    repeat (6) tick();
    chk("j6_nupd", upd_n - b_upd, 32'd4);
    chk("j6_ndone", done_n - b_done, 32'd1);
    chk("j6_nclr", clr_n - b_clr, 32'd1);
    chk("j6_rem", {27'd0, cnt_remainder}, 32'd6);
    chk("j6_w3", upd_data[(b_upd + 3) % 64], 32'h8);
    chk("j6_busy", {31'd0, busy}, 32'd0);

    // Reset in GAP after word 2 of a 3-word job
    words[0] = 32'h0000AAAA; words[1] = 32'h0000BBBB; words[2] = 32'h0000CCCC;
    run_job("j7", 16'd3, 5'd7, 1, 0, 2);
    repeat (8) tick();
    chk("j7_nupd", upd_n - b_upd, 32'd2);
    chk("j7_ndone", done_n - b_done, 32'd0);

    // Fresh job after reset: LFSR back at seed -> tie 1
    words[0] = 32'hCAFEBABE;
    run_job("j8", 16'd1, 5'd2, 1, 0, 0);
    chk("j8_nupd", upd_n - b_upd, 32'd1);
    chk("j8_w0", upd_data[b_upd % 64], 32'hCAFEBABE);
    chk("j8_last", {31'd0, upd_last[b_upd % 64]}, 32'd1);
    chk("j8_done_lat", done_cyc - upd_at(0), 32'd4);
    chk("j8_tie", {31'd0, clr_tie}, 32'd1);
    chk("j8_even", {31'd0, clr_even}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bundle_feeder.md
Name: bundle_feeder

Overview:
- Transmit-side sequencer for the majority-bundling counter bank.
- Accepts a job of N 32-bit hypervector words on a valid/ready stream and clears/initialises the counters, including the even-count tie-break seed.
- Issues one update per word, spaced to match the counter's 2-stage accumulate pipeline, flags the final word, and pulses done once every counter's sign bit is valid.

Parameters:
- W, 32: data word width; one bit lane per counter.
- LFSR_SEED, 16'hACE1: reset value of the tie-break LFSR; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle job start; ignored while busy=1
- n_items  in  16  number of words to bundle; sampled on accepted start
- cfg_remainder  in  5  remainder value for this job; sampled on accepted start
- s_data  in  W  input hypervector word
- s_valid  in  1  s_data valid
- s_ready  out  1  feeder can accept s_data
- cnt_clr  out  1  counter clear/init strobe
- cnt_even  out  1  counter init: 1 when n_items is even (tie-break needed)
- cnt_tie  out  1  counter init: tie-break polarity
- cnt_result  out  W  word presented to the counters
- cnt_update  out  1  one-cycle update strobe
- cnt_last_update  out  1  high with cnt_update on the final word
- cnt_remainder  out  5  held copy of cfg_remainder
- busy  out  1  job in progress
- done  out  1  one-cycle pulse; counter sign bits valid this cycle

Behaviour:
- Reset: FSM=IDLE; all outputs 0; LFSR=LFSR_SEED; internal item counter=0.
- Reset mid-job: abandon the job immediately; no done pulse; the next cycle is IDLE.
- IDLE: busy=0. start=1 latches n_items, cfg_remainder and cnt_tie=lfsr[0], steps the LFSR once (16-bit Fibonacci, taps 16,14,13,11), then moves to CLEAR.
- CLEAR (1 cycle): cnt_clr=1, cnt_even=~n_items[0], cnt_tie valid, busy=1.
  - n_items==0: go to DRAIN.
  - Otherwise: go to FETCH.
- FETCH: s_ready=1. On s_valid&s_ready, register s_data into cnt_result and go to ISSUE.
- ISSUE (1 cycle):
  - cnt_update=1.
  - cnt_last_update=1 iff this is word n_items.
  - Item counter increments.
  - Go to GAP.
- GAP (1 cycle):
  - Items remain: s_ready=1; a handshake goes directly to ISSUE, otherwise go to FETCH.
  - No items remain: s_ready=0; go to DRAIN.
- Update spacing: consecutive cnt_update pulses are at least 2 cycles apart. Back-to-back input sustains 1 update per 2 cycles.
- DRAIN: 2 cycles covering the counter's update->partial-sum->accumulate pipeline. Then go to DONE.
- DONE (1 cycle): done=1, busy stays 1. Next cycle IDLE, busy=0.
- Latency: the final cnt_update at cycle t gives done at cycle t+4 (t+1 GAP, t+2/t+3 DRAIN, t+4 DONE).
- Output stability:
  - cnt_result holds its value outside ISSUE.
  - cnt_remainder and cnt_even hold from CLEAR to the end of the job.
  - s_ready=0 in IDLE, CLEAR, ISSUE, DRAIN and DONE.
- start while busy=1 is ignored; latched parameters and LFSR are unchanged.
- Item counter is 16-bit; n_items=16'hFFFF must complete without wrap.

Test Plan:
- Reset, then start with n_items=3, cfg_remainder=5, words 32'hFFFF0000/32'h0F0F0F0F/32'h00000001 with s_valid always high -> exactly 3 cnt_update pulses 2 cycles apart, each cnt_result matching its word; cnt_last_update only on the 3rd pulse; cnt_remainder=5; cnt_even=0; done exactly 4 cycles after the 3rd update.
- n_items=2 -> cnt_even=1 during CLEAR and cnt_tie=LFSR_SEED bit0 (1 for 16'hACE1); a second job with n_items=2 shows the stepped LFSR bit0.
- n_items=0 -> one cnt_clr cycle, zero cnt_update, done 3 cycles after CLEAR.
- s_valid toggled 1-0-0-1 while streaming 4 words -> no update without a handshake; spacing ≥2 cycles; s_data captured only when s_valid&s_ready.
- start pulsed during ISSUE of a 4-word job -> ignored; exactly 4 updates and a single done.
- rst asserted in GAP of a 3-word job after word 2 -> next cycle all outputs 0, no done; a fresh job then runs normally.
